rf_writeback_ctrl: RTL

- Write-side initiator for the 32x32 register file. Drives the regfile write port (address, data, write enable) from two result sources.
- Source 1: the single-cycle ALU/writeback path. It has priority and no backpressure.
- Source 2: a multi-cycle unit (load / mul-div) behind a valid/ready handshake, buffered in a small FIFO.
- Keeps a destination-register scoreboard so decode can stall on pending multi-cycle results.

---
 rtl/rf_wb_pkg.sv | 15 +
 rtl/rf_wb_fifo.sv | 59 +++++
 rtl/rf_writeback_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/rf_wb_pkg.sv
// rtl/rf_wb_pkg.sv - shared types and constants for the register-file writeback controller
package rf_wb_pkg;

    localparam int NUM_REGS  = 32;
    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 32;

    localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// rtl/rf_wb_fifo.sv - synchronous FIFO of writeback requests
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  wb_req_t        push_req,
    input  logic           pop,
    output wb_req_t        head,
    output logic           full,
    output logic           empty,
    output logic [PTR_W:0] count
);

    wb_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array; contents are don't-care while the entry is not counted.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_req;
        end
    end

    // Pointers and occupancy; reset drops every buffered entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// rtl/rf_writeback_ctrl.sv - regfile write-port arbiter with scoreboard; optional RF_WB_STARVE_GUARD_EN
module rf_writeback_ctrl
    import rf_wb_pkg::*;
#(
    parameter int DATA_W       = WB_DATA_W,
    parameter int ADDR_W       = WB_ADDR_W,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    input  logic [ADDR_W-1:0]   alu_rd,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                ext_valid,
    output logic                ext_ready,
    input  logic [ADDR_W-1:0]   ext_rd,
    input  logic [DATA_W-1:0]   ext_data,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic [ADDR_W-1:0]   chk_rs1,
    input  logic [ADDR_W-1:0]   chk_rs2,
    input  logic [ADDR_W-1:0]   chk_rd,
    output logic                rd_hazard,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic                wr_en,
    output logic                alu_stall
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    wb_req_t             head;
    wb_req_t             push_req;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic                push;
    logic                sel_alu;
    logic                sel_fifo;
    logic [NUM_REGS-1:0] busy_next;

    // x0 results complete the handshake but never occupy a FIFO slot.
    assign ext_ready = !fifo_full;
    assign push      = ext_valid && ext_ready && (ext_rd != REG_ZERO);
    assign push_req  = '{rd: ext_rd, data: ext_data};

    rf_wb_fifo #(
        .DEPTH    (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_req (push_req),
        .pop      (sel_fifo),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assert property (@(posedge clk) disable iff (rst)
        fifo_full == (fifo_count == CNT_W'(FIFO_DEPTH)));

`ifdef RF_WB_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_LIMIT) + 1;

    logic [SC_W-1:0] starve_cnt;
    logic [SC_W-1:0] starve_next;

    // The stall cycle hands the port to the FIFO head; an ALU request then is dropped.
    always_comb begin
        sel_alu  = alu_valid && !alu_stall;
        sel_fifo = !fifo_empty && (alu_stall || !alu_valid);
    end

    // Count cycles the FIFO head loses to the ALU; any pop or empty FIFO restarts it.
    always_comb begin
        starve_next = starve_cnt;
        if (sel_fifo || fifo_empty) begin
            starve_next = '0;
        end else if (alu_valid) begin
            starve_next = starve_cnt + 1'b1;
        end
    end

    // One-cycle stall pulse once the head has been blocked STARVE_LIMIT-1 times.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            alu_stall  <= 1'b0;
        end else begin
            starve_cnt <= starve_next;
            alu_stall  <= !alu_stall && (starve_next == SC_W'(STARVE_LIMIT - 1));
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(alu_stall && alu_valid));
`else
    // Strict ALU priority; the FIFO only drains in ALU-idle cycles.
    always_comb begin
        sel_alu  = alu_valid;
        sel_fifo = !alu_valid && !fifo_empty;
    end

    assign alu_stall = 1'b0;

    assert property (@(posedge clk) disable iff (rst) STARVE_LIMIT >= 2);
`endif

    // Registered write port; idle cycles keep the last address and data.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (sel_alu) begin
            wr_en   <= (alu_rd != REG_ZERO);
            wr_addr <= alu_rd;
            wr_data <= alu_data;
        end else if (sel_fifo) begin
            wr_en   <= (head.rd != REG_ZERO);
            wr_addr <= head.rd;
            wr_data <= head.data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // Scoreboard update: pop clears, issue sets and wins a same-cycle clash.
    always_comb begin
        busy_next = busy_mask;
        if (sel_fifo) begin
            busy_next[head.rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != REG_ZERO)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[REG_ZERO] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_mask <= '0;
        end else begin
            busy_mask <= busy_next;
        end
    end

    assign rd_hazard = busy_mask[chk_rs1] | busy_mask[chk_rs2] | busy_mask[chk_rd];

endmodule
